// File: rtl/bcd_disp_pkg.sv
// Shared types, 7-segment constants and helpers for the binary-to-BCD display path.
package bcd_disp_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} conv_state_t;

   // Segment order {a,b,c,d,e,f,g}, active-low
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };

   function automatic logic [3:0] add3_nibble(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD digit to an active-low 7-segment pattern; non-decimal nibbles show blank.
module bcd_to_seg7
   import bcd_disp_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      if (!blank && digit <= 4'd9) seg_c = SEG_DIGIT[digit];
   end

endmodule

// File: rtl/bin_bcd_display.sv
// Sequential double-dabble converter (one bit per clock) feeding DIGITS 7-segment displays,
// with start/done handshake, leading-zero blanking and overflow dashes.
module bin_bcd_display
   import bcd_disp_pkg::*;
#(
   parameter int unsigned BIN_W    = 8,
   parameter int unsigned DIGITS   = 3,
   parameter int unsigned BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   seg_out
);

   localparam int unsigned     SCR_W   = 4 * DIGITS;
   localparam int unsigned     SEG_W   = 7 * DIGITS;
   localparam int unsigned     CNT_W   = $clog2(BIN_W + 1);
   localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

   conv_state_t       state, state_next;
   logic [BIN_W-1:0]  shreg;
   logic [SCR_W-1:0]  scratch;
   logic [SCR_W-1:0]  scratch_adj_c;
   logic [CNT_W-1:0]  cnt;
   logic              ovf_pend;
   logic              load_c, shift_c, finish_c;
   logic              seen_c;
   logic [DIGITS-1:0] blank_c;
   logic [SEG_W-1:0]  seg_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      load_c     = 1'b0;
      shift_c    = 1'b0;
      finish_c   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_c     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            shift_c = 1'b1;
            if (cnt == CNT_W'(1)) state_next = FINISH;
         end
         FINISH: begin
            finish_c   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Add-3 correction on every nibble before the shift
   always_comb begin
      scratch_adj_c = '0;
      for (int unsigned k = 0; k < DIGITS; k++)
         scratch_adj_c[4*k +: 4] = add3_nibble(scratch[4*k +: 4]);
   end

   // Blank digits above the most-significant nonzero one; units digit always shown
   always_comb begin
      seen_c  = 1'b0;
      blank_c = '0;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         if (scratch[4*k +: 4] != 4'd0) seen_c = 1'b1;
         blank_c[k] = (BLANK_LZ != 0) && !seen_c && (k != 0);
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      bcd_to_seg7 u_seg (
         .digit (scratch[4*g +: 4]),
         .blank (blank_c[g]),
         .seg_c (seg_c[7*g +: 7])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg    <= '0;
         scratch  <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ovf      <= 1'b0;
         bcd_out  <= '0;
         seg_out  <= '1;
      end else begin
         done <= finish_c;
         if (load_c) begin
            shreg    <= bin_in;
            scratch  <= '0;
            cnt      <= CNT_W'(BIN_W);
            ovf_pend <= (64'(bin_in) > MAX_VAL);
            busy     <= 1'b1;
         end
         if (shift_c) begin
            scratch <= {scratch_adj_c[SCR_W-2:0], shreg[BIN_W-1]};
            shreg   <= shreg << 1;
            cnt     <= cnt - CNT_W'(1);
         end
         if (finish_c) begin
            busy    <= 1'b0;
            bcd_out <= scratch;
            ovf     <= ovf_pend;
            seg_out <= ovf_pend ? {DIGITS{SEG_DASH}} : seg_c;
         end
      end
   end

endmodule
